// File: rtl/ir_assembler_if.sv
// Bus bundle between the ROM/RAM data bus, the instruction register and the CPU controller.
// The master side drives beats and control; the slave side (ir_assembler) returns the assembled word and status.
interface ir_assembler_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned BEATS  = 2,
  parameter int unsigned OPC_W  = 3
);
  localparam int unsigned IR_W   = DATA_W * BEATS;
  localparam int unsigned ADDR_W = IR_W - OPC_W;
  localparam int unsigned CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;

  logic [DATA_W-1:0] data;
  logic              ena;
  logic              clr;
  logic              data_par;
  logic [IR_W-1:0]   opc_iraddr;
  logic [OPC_W-1:0]  opcode;
  logic [ADDR_W-1:0] iraddr;
  logic              ir_valid;
  logic              busy;
  logic [CNT_W-1:0]  beat_cnt;
  logic              par_err;

  modport master (
    output data, ena, clr, data_par,
    input  opc_iraddr, opcode, iraddr, ir_valid, busy, beat_cnt, par_err
  );

  modport slave (
    input  data, ena, clr, data_par,
    output opc_iraddr, opcode, iraddr, ir_valid, busy, beat_cnt, par_err
  );
endinterface

// File: rtl/ir_assembler.sv
// Instruction register: assembles BEATS bus beats (MSB beat first) into one word, split into opcode/address.
// Optional even-parity checking on every loaded beat is enabled by defining PARITY_EN.
module ir_assembler #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned BEATS  = 2,
  parameter int unsigned OPC_W  = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  ir_assembler_if.slave bus
);
  localparam int unsigned IR_W   = DATA_W * BEATS;
  localparam int unsigned ADDR_W = IR_W - OPC_W;
  localparam int unsigned CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  logic [IR_W-1:0]  word_q,  word_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic             valid_q, valid_d;
  logic             busy_q,  busy_d;
  logic             par_bad;

`ifdef PARITY_EN
  logic perr_q, perr_d;

  assign par_bad = ^{bus.data, bus.data_par};

  // Sticky parity error, cleared only by reset or clr
  always_comb begin
    perr_d = perr_q;
    if (bus.clr)                 perr_d = 1'b0;
    else if (bus.ena && par_bad) perr_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) perr_q <= 1'b0;
    else        perr_q <= perr_d;
  end

  assign bus.par_err = perr_q;
`else
  logic unused_par;
  assign unused_par  = bus.data_par;
  assign par_bad     = 1'b0;
  assign bus.par_err = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      word_q  <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      word_q  <= word_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
    end
  end

  // Next state: clr beats ena; a dropped enable abandons the partial word but keeps the register contents
  always_comb begin
    word_d  = word_q;
    cnt_d   = cnt_q;
    valid_d = 1'b0;
    if (bus.clr) begin
      cnt_d = '0;
    end else if (bus.ena) begin
      for (int unsigned b = 0; b < BEATS; b++) begin
        if (cnt_q == CNT_W'(b)) word_d[IR_W-1-b*DATA_W -: DATA_W] = bus.data;
      end
      if (par_bad) begin
        cnt_d = '0;
      end else if (cnt_q == LAST_BEAT) begin
        cnt_d   = '0;
        valid_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else begin
      cnt_d = '0;
    end
    busy_d = (cnt_d != '0);
  end

  // Outputs: registered state plus pure field slices of the word
  always_comb begin
    bus.opc_iraddr = word_q;
    bus.opcode     = word_q[IR_W-1 -: OPC_W];
    bus.iraddr     = word_q[ADDR_W-1:0];
    bus.ir_valid   = valid_q;
    bus.busy       = busy_q;
    bus.beat_cnt   = cnt_q;
  end
endmodule
